// File: rtl/alu_writeback_bank_pkg.sv
// Shared select, op and state encodings for the write-back bank and the
// ALU operand multiplexers that read the same register set.
package alu_sel_pkg;

    localparam int DATA_W    = 18;
    localparam int SEL_W     = 4;
    localparam int NUM_REGS  = 9;
    localparam int REG_IDX_W = 4;

    // Ten operand sources; IDR is read-only, so only MDR..RCOLTEMP are writable.
    typedef enum logic [SEL_W-1:0] {
        SEL_NONE     = 4'b0000,
        SEL_IDR      = 4'b0001,
        SEL_MDR      = 4'b0010,
        SEL_RCOL     = 4'b0011,
        SEL_RROW     = 4'b0100,
        SEL_RI       = 4'b0101,
        SEL_RJ       = 4'b0110,
        SEL_RTOTAL   = 4'b0111,
        SEL_ADDRESS  = 4'b1000,
        SEL_RBND     = 4'b1001,
        SEL_RCOLTEMP = 4'b1010
    } sel_e;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_DEC  = 2'b11
    } wb_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } wb_state_e;

    localparam logic [REG_IDX_W-1:0] IDX_MDR = '0;

    function automatic logic sel_is_writable(input logic [SEL_W-1:0] sel);
        return (sel >= SEL_MDR) && (sel <= SEL_RCOLTEMP);
    endfunction

    // Register-array slot for a writable select; illegal selects map to slot 0
    // but are never allowed to commit.
    function automatic logic [REG_IDX_W-1:0] sel_to_idx(input logic [SEL_W-1:0] sel);
        return sel_is_writable(sel) ? REG_IDX_W'(sel - SEL_MDR) : '0;
    endfunction

endpackage

// File: rtl/alu_writeback_bank_if.sv
// Write-back request/response handshake between the ALU and the register bank.
interface alu_writeback_bank_if;
    import alu_sel_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic [SEL_W-1:0]  wb_sel;
    logic [1:0]        wb_op;
    logic [DATA_W-1:0] wb_data;
    logic              wb_done;
    logic              wb_err;

    modport master (
        output wb_valid, wb_sel, wb_op, wb_data,
        input  wb_ready, wb_done, wb_err
    );

    modport slave (
        input  wb_valid, wb_sel, wb_op, wb_data,
        output wb_ready, wb_done, wb_err
    );

endinterface

// File: rtl/alu_writeback_bank_wb_op_unit.sv
// Combinational new-value generator for a write-back: LOAD/INC/CLR/DEC,
// all wrapping modulo 2^DATA_W.
module wb_op_unit
    import alu_sel_pkg::*;
(
    input  wb_op_e            op,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = cur;
        case (op)
            OP_LOAD: result = data;
            OP_INC:  result = cur + DATA_W'(1);
            OP_CLR:  result = '0;
            OP_DEC:  result = cur - DATA_W'(1);
            default: result = cur;
        endcase
    end

endmodule

// File: rtl/alu_writeback_bank.sv
// Datapath register bank closing the ALU loop on the write side, with a direct
// memory load port into MDR. Optional macro ALU_WB_BYPASS_EN forwards the pending value.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; wb_ready high
// ST_HOLD | request latched; commit on next edge unless memory owns MDR
module alu_writeback_bank
    import alu_sel_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_writeback_bank_if.slave  wb,
    input  logic                 mem_load_en,
    input  logic [DATA_W-1:0]    mem_load_data,
    output logic [DATA_W-1:0]    dout_mdr,
    output logic [DATA_W-1:0]    dout_rcol,
    output logic [DATA_W-1:0]    dout_rrow,
    output logic [DATA_W-1:0]    dout_ri,
    output logic [DATA_W-1:0]    dout_rj,
    output logic [DATA_W-1:0]    dout_rtotal,
    output logic [DATA_W-1:0]    dout_address,
    output logic [DATA_W-1:0]    dout_rbnd,
    output logic [DATA_W-1:0]    dout_rcoltemp
);

    wb_state_e             state_q;
    wb_state_e             state_d;
    logic [SEL_W-1:0]      sel_q;
    wb_op_e                op_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     regs_q   [NUM_REGS];
    logic [DATA_W-1:0]     dout_arr [NUM_REGS];
    logic [DATA_W-1:0]     cur_val;
    logic [DATA_W-1:0]     new_val;
    logic [REG_IDX_W-1:0]  tgt_idx;
    logic                  sel_legal;
    logic                  collision;
    logic                  accept;
    logic                  commit;
    logic                  done_d;
    logic                  err_d;
    logic                  done_q;
    logic                  err_q;

    assign sel_legal = sel_is_writable(sel_q);
    assign tgt_idx   = sel_to_idx(sel_q);
    assign cur_val   = regs_q[tgt_idx];

    // Memory owns MDR while it loads; a pending MDR write-back waits a cycle.
    assign collision = (state_q == ST_HOLD) && (sel_q == SEL_MDR) && mem_load_en;

    wb_op_unit u_op_unit (
        .op     (op_q),
        .data   (data_q),
        .cur    (cur_val),
        .result (new_val)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb.wb_valid) begin
                    accept  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!collision) begin
                    commit  = sel_legal;
                    done_d  = 1'b1;
                    err_d   = !sel_legal;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                sel_q  <= wb.wb_sel;
                op_q   <= wb_op_e'(wb.wb_op);
                data_q <= wb.wb_data;
            end
            if (mem_load_en) begin
                regs_q[IDX_MDR] <= mem_load_data;
            end
            if (commit) begin
                regs_q[tgt_idx] <= new_val;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            dout_arr[i] = regs_q[i];
        end
`ifdef ALU_WB_BYPASS_EN
        if ((state_q == ST_HOLD) && sel_legal) begin
            dout_arr[tgt_idx] = collision ? mem_load_data : new_val;
        end
`endif
    end

    assign wb.wb_ready = (state_q == ST_IDLE);
    assign wb.wb_done  = done_q;
    assign wb.wb_err   = err_q;

    assign dout_mdr      = dout_arr[0];
    assign dout_rcol     = dout_arr[1];
    assign dout_rrow     = dout_arr[2];
    assign dout_ri       = dout_arr[3];
    assign dout_rj       = dout_arr[4];
    assign dout_rtotal   = dout_arr[5];
    assign dout_address  = dout_arr[6];
    assign dout_rbnd     = dout_arr[7];
    assign dout_rcoltemp = dout_arr[8];

endmodule

// File: tb/tb_alu_writeback_bank.sv
// Directed plus randomized bench for alu_writeback_bank with a simple array
// model of the nine writable registers.
`timescale 1ns/1ps
module tb_alu_writeback_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_load_en = 1'b0;
    logic [17:0] mem_load_data = '0;
    logic [17:0] dout_mdr, dout_rcol, dout_rrow, dout_ri, dout_rj;
    logic [17:0] dout_rtotal, dout_address, dout_rbnd, dout_rcoltemp;

    alu_writeback_bank_if wbi();

    alu_writeback_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (wbi.slave),
        .mem_load_en   (mem_load_en),
        .mem_load_data (mem_load_data),
        .dout_mdr      (dout_mdr),
        .dout_rcol     (dout_rcol),
        .dout_rrow     (dout_rrow),
        .dout_ri       (dout_ri),
        .dout_rj       (dout_rj),
        .dout_rtotal   (dout_rtotal),
        .dout_address  (dout_address),
        .dout_rbnd     (dout_rbnd),
        .dout_rcoltemp (dout_rcoltemp)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [17:0] model [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour: plain integer arithmetic modulo 2^18.
    function automatic logic [17:0] ref_next(input int op, input logic [17:0] d, input logic [17:0] c);
        int r;
        case (op)
            0: r = int'(d);
            1: r = (int'(c) + 1) % 262144;
            2: r = 0;
            default: r = (int'(c) + 262143) % 262144;
        endcase
        return 18'(r);
    endfunction

    function automatic logic [17:0] get_dout(input int idx);
        case (idx)
            0: return dout_mdr;
            1: return dout_rcol;
            2: return dout_rrow;
            3: return dout_ri;
            4: return dout_rj;
            5: return dout_rtotal;
            6: return dout_address;
            7: return dout_rbnd;
            default: return dout_rcoltemp;
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), get_dout(i), model[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wbi.wb_valid = 1'b0;
        mem_load_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) model[i] = '0;
    endtask

    // One full request: accept at E0, optional MDR collision cycles, retire at E1.
    task automatic wb_req(input logic [3:0] sel, input logic [1:0] op, input logic [17:0] data,
                          input int n_coll, input logic [17:0] coll_data);
        bit          legal;
        int          idx;
        logic [17:0] expv;
        legal = (sel >= 4'd2) && (sel <= 4'd10);
        idx   = legal ? int'(sel) - 2 : 0;
        chk("ready_idle", wbi.wb_ready, 1);
        wbi.wb_valid = 1'b1;
        wbi.wb_sel   = sel;
        wbi.wb_op    = op;
        wbi.wb_data  = data;
        tick();
        wbi.wb_valid = 1'b0;
        wbi.wb_data  = 18'(~data);
        chk("ready_hold", wbi.wb_ready, 0);
        chk("done_hold", wbi.wb_done, 0);
        if (legal && n_coll == 0) begin
`ifdef ALU_WB_BYPASS_EN
            expv = ref_next(int'(op), data, model[idx]);
`else
            expv = model[idx];
`endif
            chk("hold_dout", get_dout(idx), expv);
        end
        for (int k = 0; k < n_coll; k++) begin
            mem_load_en   = 1'b1;
            mem_load_data = coll_data;
            tick();
            model[0] = coll_data;
            chk("coll_mdr", dout_mdr, coll_data);
            chk("coll_done", wbi.wb_done, 0);
            chk("coll_ready", wbi.wb_ready, 0);
        end
        mem_load_en = 1'b0;
        tick();
        if (legal) model[idx] = ref_next(int'(op), data, model[idx]);
        chk("done_e1", wbi.wb_done, 1);
        chk("err_e1", wbi.wb_err, legal ? 0 : 1);
        chk("ready_e1", wbi.wb_ready, 1);
        check_all("commit");
        tick();
        chk("done_e2", wbi.wb_done, 0);
        chk("err_e2", wbi.wb_err, 0);
    endtask

    initial begin
        wbi.wb_valid = 1'b0;
        wbi.wb_sel   = '0;
        wbi.wb_op    = '0;
        wbi.wb_data  = '0;

        do_reset();
        chk("rst_ready", wbi.wb_ready, 1);
        chk("rst_done", wbi.wb_done, 0);
        chk("rst_err", wbi.wb_err, 0);
        check_all("rst");

        wb_req(4'b0101, 2'b00, 18'h00123, 0, '0);

        wb_req(4'b0111, 2'b00, 18'h3FFFF, 0, '0);
        wb_req(4'b0111, 2'b01, 18'h00000, 0, '0);
        chk("inc_wrap", dout_rtotal, 18'h00000);
        wb_req(4'b0110, 2'b11, 18'h00000, 0, '0);
        chk("dec_wrap", dout_rj, 18'h3FFFF);

        wb_req(4'b0001, 2'b00, 18'h2BEEF, 0, '0);
        wb_req(4'b1100, 2'b01, 18'h11111, 0, '0);
        wb_req(4'b0000, 2'b10, 18'h0, 0, '0);

        wb_req(4'b0010, 2'b00, 18'h00AAA, 2, 18'h00555);
        chk("coll_final", dout_mdr, 18'h00AAA);
        wb_req(4'b0010, 2'b01, 18'h0, 1, 18'h01000);
        chk("coll_inc", dout_mdr, 18'h01001);

        wb_req(4'b0011, 2'b00, 18'h00042, 0, '0);
        wb_req(4'b1010, 2'b10, 18'h3AAAA, 0, '0);

        mem_load_en   = 1'b1;
        mem_load_data = 18'h2468A;
        tick();
        mem_load_en = 1'b0;
        model[0] = 18'h2468A;
        chk("memload_idle", dout_mdr, 18'h2468A);

        // Reset while a request is in HOLD: discarded, no done.
        wbi.wb_valid = 1'b1;
        wbi.wb_sel   = 4'b0101;
        wbi.wb_op    = 2'b00;
        wbi.wb_data  = 18'h00777;
        tick();
        wbi.wb_valid = 1'b0;
        chk("rsth_ready", wbi.wb_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) model[i] = '0;
        chk("rsth_done", wbi.wb_done, 0);
        chk("rsth_ready1", wbi.wb_ready, 1);
        check_all("rsth");
        tick();
        chk("rsth_done2", wbi.wb_done, 0);
        chk("rsth_ri", dout_ri, 18'h0);

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  s;
            logic [1:0]  o;
            logic [17:0] d;
            int          nc;
            s  = 4'($urandom_range(0, 15));
            o  = 2'($urandom_range(0, 3));
            d  = 18'($urandom);
            nc = (s == 4'b0010) ? int'($urandom_range(0, 2)) : 0;
            if ($urandom_range(0, 3) == 0) begin
                mem_load_en   = 1'b1;
                mem_load_data = 18'($urandom);
                tick();
                mem_load_en = 1'b0;
                model[0] = mem_load_data;
                chk("rnd_memload", dout_mdr, model[0]);
            end
            wb_req(s, o, d, nc, 18'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
